// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment scanner for NDIG hex digits.
// Each digit owns a slot of DIV cycles. The first GAP cycles of every slot
// are blanked so that anode and segment changes never overlap visibly.
// Both outputs are registered and are computed from the pre-edge counter,
// digit index and display latch.
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
// Digit 0 is never blanked.
module seg_scan #(
    parameter int NDIG = 4,
    parameter int DIV  = 1000,
    parameter int GAP  = 2
) (
    input  logic                seg_scani_clk,
    input  logic                seg_scani_rst,
    input  logic                seg_scani_en,
    input  logic                seg_scani_load,
    input  logic [4*NDIG-1:0]   seg_scani_data,
    output logic [6:0]          seg_scano_seg,
    output logic [NDIG-1:0]     seg_scano_an
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [CW-1:0]      cnt_reg;
    logic [IW-1:0]      idx_reg;
    logic [4*NDIG-1:0]  latch_reg;
    logic [6:0]         seg_reg;
    logic [NDIG-1:0]    an_reg;

    logic [3:0]         nib [NDIG];
    logic [3:0]         cur_nib;
    logic [6:0]         code;
    logic               lit;
    logic               cnt_last;
    logic [6:0]         seg_next;
    logic [NDIG-1:0]    an_next;

    // Split the latch into per-digit nibbles so the active one can be muxed.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
            assign nib[gi] = latch_reg[4*gi +: 4];
        end
    endgenerate

`ifdef SEG_SCAN_LZB_EN
    // blank[i] is set when digit i and every more significant digit are zero.
    logic [NDIG-1:0] blank;
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NDIG; gi++) begin : g_blank
            assign blank[gi] = ~|latch_reg[4*NDIG-1:4*gi];
        end
    endgenerate
`endif

    assign cnt_last = (cnt_reg == CW'(DIV - 1));
    assign cur_nib  = nib[idx_reg];
    assign lit      = seg_scani_en && (cnt_reg >= CW'(GAP));

    // Hex nibble to segment pattern, bit0 = a through bit6 = g.
    always_comb begin
        code = 7'h00;
        case (cur_nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            default: code = 7'h71;
        endcase
    end

    // Next output values: dark while disabled or inside the slot gap.
    always_comb begin
        an_next  = '0;
        seg_next = '0;
        if (lit) begin
            an_next  = {{(NDIG-1){1'b0}}, 1'b1} << idx_reg;
            seg_next = code;
`ifdef SEG_SCAN_LZB_EN
            if (blank[idx_reg]) begin
                seg_next = '0;
            end
`endif
        end
    end

    // Slot counter and digit index advance only while scanning is enabled.
    always_ff @(posedge seg_scani_clk) begin
        if (seg_scani_rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (seg_scani_en) begin
            if (cnt_last) begin
                cnt_reg <= '0;
                idx_reg <= (idx_reg == IW'(NDIG - 1)) ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Display latch captures new data on every load strobe.
    always_ff @(posedge seg_scani_clk) begin
        if (seg_scani_rst) begin
            latch_reg <= '0;
        end else if (seg_scani_load) begin
            latch_reg <= seg_scani_data;
        end
    end

    // Registered outputs so the pins never see decode glitches.
    always_ff @(posedge seg_scani_clk) begin
        if (seg_scani_rst) begin
            seg_reg <= '0;
            an_reg  <= '0;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign seg_scano_seg = seg_reg;
    assign seg_scano_an  = an_reg;

endmodule
